// File: rtl/mems_pkg.sv
// Shared constants for the MEMS sequencer and its DAC serial back-end.
package mems_pkg;

  // DAC command word layout; the sequencer ROM builds words with the same offsets.
  localparam int unsigned DAC_FRAME_BITS = 24;
  localparam int unsigned DAC_CMD_MSB    = 23;
  localparam int unsigned DAC_CMD_LSB    = 19;
  localparam int unsigned DAC_ADDR_MSB   = 18;
  localparam int unsigned DAC_ADDR_LSB   = 16;
  localparam int unsigned DAC_DATA_MSB   = 15;
  localparam int unsigned DAC_DATA_LSB   = 0;

  // Serial FSM state encoding.
  typedef logic [2:0] state_t;
  localparam state_t StIdle = 3'd0;
  localparam state_t StLead = 3'd1;
  localparam state_t StLow  = 3'd2;
  localparam state_t StHigh = 3'd3;
  localparam state_t StGap  = 3'd4;

  // Assemble a DAC command word from its fields.
  function automatic logic [DAC_FRAME_BITS-1:0] dac_word(input logic [4:0]  cmd,
                                                          input logic [2:0]  addr,
                                                          input logic [15:0] data);
    return {cmd, addr, data};
  endfunction

endpackage

// File: rtl/mems_spi_tick.sv
// Loadable down-counter; tick_o is high on the cycle the count reaches zero, so a
// load of N-1 yields a phase-end tick after N cycles.
module mems_spi_tick (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       tick_o
);

  logic [7:0] cnt_q, cnt_d;

  // Load has priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == 8'd0);

endmodule

// File: rtl/mems_dac_spi.sv
// 3-wire SPI back-end: shifts one 24-bit DAC word MSB-first per accepted start,
// then holds sync_n high for a minimum gap before the next frame.
module mems_dac_spi
  import mems_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned FRAME_BITS = DAC_FRAME_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [FRAME_BITS-1:0] data_in_i,
  output logic                  busy_o,
  output logic                  new_data_o,
  output logic                  sclk_o,
  output logic                  sync_n_o,
  output logic                  mosi_o,
  output logic [15:0]           frame_count_o
);

  localparam logic [7:0] PhaseLoad = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapLoad   = 8'(GAP_CYCLES - 1);
  localparam logic [4:0] LastBit   = 5'(FRAME_BITS);

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic                  busy_q, busy_d;
  logic                  new_data_q, new_data_d;
  logic                  sclk_q, sclk_d;
  logic                  sync_n_q, sync_n_d;
  logic [15:0]           frame_count_q, frame_count_d;

  logic                  tick;
  logic                  tick_load;
  logic [7:0]            tick_val;

  mems_spi_tick u_tick (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tick_load),
    .load_val_i (tick_val),
    .tick_o     (tick)
  );

  // Frame sequencing; every phase change reloads the tick counter.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    busy_d        = busy_q;
    new_data_d    = 1'b0;
    sclk_d        = sclk_q;
    sync_n_d      = sync_n_q;
    frame_count_d = frame_count_q;
    tick_load     = 1'b0;
    tick_val      = PhaseLoad;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          shift_d   = data_in_i;
          bit_cnt_d = 5'd0;
          busy_d    = 1'b1;
          sync_n_d  = 1'b0;
          sclk_d    = 1'b1;
          tick_load = 1'b1;
          state_d   = StLead;
        end
      end
      StLead: begin
        if (tick) begin
          sclk_d    = 1'b0;
          tick_load = 1'b1;
          state_d   = StLow;
        end
      end
      StLow: begin
        if (tick) begin
          sclk_d    = 1'b1;
          tick_load = 1'b1;
          bit_cnt_d = bit_cnt_q + 5'd1;
          state_d   = StHigh;
          // After the last low phase mosi keeps the final bit.
          if (bit_cnt_q != LastBit - 5'd1) begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      StHigh: begin
        if (tick) begin
          tick_load = 1'b1;
          if (bit_cnt_q == LastBit) begin
            sync_n_d      = 1'b1;
            new_data_d    = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            tick_val      = GapLoad;
            state_d       = StGap;
          end else begin
            sclk_d  = 1'b0;
            state_d = StLow;
          end
        end
      end
      StGap: begin
        // busy drops one cycle before IDLE so a start on the busy-fall cycle is dropped.
        if (!busy_q) begin
          state_d = StIdle;
        end else if (tick) begin
          busy_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      shift_q       <= '0;
      bit_cnt_q     <= 5'd0;
      busy_q        <= 1'b0;
      new_data_q    <= 1'b0;
      sclk_q        <= 1'b1;
      sync_n_q      <= 1'b1;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      busy_q        <= busy_d;
      new_data_q    <= new_data_d;
      sclk_q        <= sclk_d;
      sync_n_q      <= sync_n_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign busy_o        = busy_q;
  assign new_data_o    = new_data_q;
  assign sclk_o        = sclk_q;
  assign sync_n_o      = sync_n_q;
  assign mosi_o        = shift_q[FRAME_BITS-1];
  assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_mems_dac_spi.sv
// Directed bench for mems_dac_spi: a default instance (CLK_DIV=2, GAP_CYCLES=2) and a
// fast instance (CLK_DIV=1, GAP_CYCLES=1) driven by a model sequencer.
module tb_mems_dac_spi;
  import mems_pkg::*;

  logic        clk;
  logic        rst_n;

  logic        a_start, a_busy, a_nd, a_sclk, a_sync_n, a_mosi;
  logic [23:0] a_data;
  logic [15:0] a_fc;
  logic        b_start, b_busy, b_nd, b_sclk, b_sync_n, b_mosi;
  logic [23:0] b_data;
  logic [15:0] b_fc;

  int n_checks = 0;
  int n_errors = 0;
  int scyc     = 0;

  // Monitor state, default instance.
  logic [23:0] a_rx;
  int a_falls, a_ndcnt, a_ndat, a_first, a_last, a_bcnt, a_hirun, a_gaprun;
  logic a_seen, a_psclk;

  // Monitor state, fast instance.
  logic [23:0] b_rx;
  int b_idx, b_run, b_ndcnt;
  logic b_pbusy, b_psclk, b_sprev;
  logic [23:0] tab [4];

  mems_dac_spi u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (a_start),
    .data_in_i     (a_data),
    .busy_o        (a_busy),
    .new_data_o    (a_nd),
    .sclk_o        (a_sclk),
    .sync_n_o      (a_sync_n),
    .mosi_o        (a_mosi),
    .frame_count_o (a_fc)
  );

  mems_dac_spi #(
    .CLK_DIV    (1),
    .GAP_CYCLES (1)
  ) u_dut_fast (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (b_start),
    .data_in_i     (b_data),
    .busy_o        (b_busy),
    .new_data_o    (b_nd),
    .sclk_o        (b_sclk),
    .sync_n_o      (b_sync_n),
    .mosi_o        (b_mosi),
    .frame_count_o (b_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    a_rx = '0; a_falls = 0; a_ndcnt = 0; a_ndat = -1;
    a_first = -1; a_last = -1; a_bcnt = 0; a_seen = 1'b0;
  endtask

  // Advance to the next falling clock edge and update both monitors.
  task automatic step();
    @(negedge clk);
    scyc++;
    if (a_busy) begin
      if (!a_seen) begin a_first = scyc; a_seen = 1'b1; end
      a_last = scyc;
      a_bcnt++;
    end
    if (a_nd) begin a_ndcnt++; a_ndat = scyc; end
    if (a_psclk && !a_sclk && !a_sync_n) begin a_rx = {a_rx[22:0], a_mosi}; a_falls++; end
    a_psclk = a_sclk;
    if (a_sync_n) a_hirun++;
    else begin
      if (a_hirun != 0) a_gaprun = a_hirun;
      a_hirun = 0;
    end
    if (b_busy && !b_pbusy) begin b_rx = '0; b_idx++; b_run = 0; end
    if (b_busy) b_run++;
    if (!b_busy && b_pbusy) check("t4_busy_len", b_run, 50);
    b_pbusy = b_busy;
    if (b_psclk && !b_sclk && !b_sync_n) b_rx = {b_rx[22:0], b_mosi};
    b_psclk = b_sclk;
    if (b_nd) begin
      b_ndcnt++;
      check("t4_frame_data", b_rx, tab[(b_idx + 3) % 4]);
    end
  endtask

  initial begin
    int t0, t1, viol;
    tab[0] = 24'h800001; tab[1] = 24'h7FFFFE; tab[2] = 24'h123456; tab[3] = 24'hFEDCBA;
    rst_n = 1'b0;
    a_start = 1'b0; a_data = '0; b_start = 1'b0; b_data = '0;
    a_psclk = 1'b1; a_hirun = 0; a_gaprun = 0;
    b_rx = '0; b_idx = 0; b_run = 0; b_ndcnt = 0; b_pbusy = 1'b0; b_psclk = 1'b1;
    b_sprev = 1'b0;
    mon_clear();

    // Test 1: reset values, then 50 idle cycles.
    step(); step();
    check("rst_sclk", a_sclk, 1);
    check("rst_sync_n", a_sync_n, 1);
    check("rst_busy", a_busy, 0);
    check("rst_new_data", a_nd, 0);
    check("rst_mosi", a_mosi, 0);
    check("rst_frame_count", a_fc, 0);
    rst_n = 1'b1;
    viol = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (a_sclk !== 1'b1 || a_sync_n !== 1'b1 || a_busy !== 1'b0 || a_fc !== 16'd0) viol++;
    end
    check("t1_idle_hold", viol, 0);

    // Tests 2/3: one frame, starts at T+50 and T+101 dropped, T+102 accepted.
    mon_clear();
    a_start = 1'b1; a_data = 24'h3FA5C3; t0 = scyc;
    for (int k = 1; k <= 102; k++) begin
      step();
      a_start = (k == 50 || k == 101);
      a_data  = 24'(k * 7919);
    end
    check("t2_busy_first", a_first - t0, 1);
    check("t2_busy_last", a_last - t0, 100);
    check("t2_busy_cycles", a_bcnt, 100);
    check("t2_sclk_falls", a_falls, 24);
    check("t2_rx_data", a_rx, 24'h3FA5C3);
    check("t2_new_data_count", a_ndcnt, 1);
    check("t2_new_data_at", a_ndat - t0, 99);
    check("t2_frame_count", a_fc, 1);
    check("t3_busy_after_drop", a_busy, 0);

    mon_clear();
    a_start = 1'b1; a_data = dac_word(5'h18, 3'h0, 16'hFFEE); t1 = scyc;
    for (int k = 1; k <= 104; k++) begin
      step();
      a_start = 1'b0;
      a_data  = 24'(k * 31);
    end
    check("t3_sync_gap", a_gaprun, 4);
    check("t3_rx_data", a_rx, 24'hC0FFEE);
    check("t3_new_data_at", a_ndat - t1, 99);
    check("t3_busy_cycles", a_bcnt, 100);
    check("t3_frame_count", a_fc, 2);

    // Test 4: fast instance, model sequencer issues on !busy until four frames complete.
    for (int k = 0; k < 600 && b_ndcnt < 4; k++) begin
      step();
      b_start = (!b_busy && !b_sprev && b_idx < 4);
      b_data  = tab[b_idx % 4];
      b_sprev = b_start;
    end
    b_start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("t4_new_data_count", b_ndcnt, 4);
    check("t4_frame_count", b_fc, 4);

    // Test 5: asynchronous reset during bit 10, then a clean frame.
    mon_clear();
    a_start = 1'b1; a_data = 24'h555555;
    for (int k = 0; k < 200 && a_falls < 9; k++) begin
      step();
      a_start = 1'b0;
    end
    check("t5_reached_bit10", a_falls, 9);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("t5_sync_n_async", a_sync_n, 1);
    check("t5_sclk_async", a_sclk, 1);
    check("t5_busy_async", a_busy, 0);
    for (int k = 0; k < 110; k++) step();
    check("t5_no_new_data", a_ndcnt, 0);
    check("t5_frame_count_rst", a_fc, 0);
    rst_n = 1'b1;
    step();
    mon_clear();
    a_start = 1'b1; a_data = 24'h000001;
    for (int k = 0; k < 105; k++) begin
      step();
      a_start = 1'b0;
    end
    check("t5_rx_data", a_rx, 24'h000001);
    check("t5_sclk_falls", a_falls, 24);
    check("t5_new_data_count", a_ndcnt, 1);
    check("t5_frame_count", a_fc, 1);

    // Test 6: preload the counter near the top, then wrap through 0xFFFF.
    force u_dut.frame_count_q = 16'hFFFE;
    step();
    release u_dut.frame_count_q;
    a_start = 1'b1; a_data = 24'hABCDEF;
    for (int k = 0; k < 105; k++) begin
      step();
      a_start = 1'b0;
    end
    check("t6_count_ffff", a_fc, 16'hFFFF);
    mon_clear();
    a_start = 1'b1; a_data = 24'h0F0F0F;
    for (int k = 0; k < 105; k++) begin
      step();
      a_start = 1'b0;
    end
    check("t6_count_wrap", a_fc, 16'h0000);
    check("t6_new_data_count", a_ndcnt, 1);
    check("t6_rx_data", a_rx, 24'h0F0F0F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
